edge_raster: RTL

EDGE_RASTER -- requirements
Module: edge_raster

---
 rtl/edge_raster.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/edge_raster.sv
// Bresenham edge rasterizer: draws the three edges of a triangle into a BOX_DIM x BOX_DIM bitmap.
// Define EDGE_RASTER_CLIP_DETECT_EN to report out-of-window pixels on clip_err.
module edge_raster #(
  parameter int BOX_DIM = 64
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [47:0]                coordinates,
  output logic                       busy,
  output logic                       done,
  output logic                       raster_valid,
  output logic [BOX_DIM*BOX_DIM-1:0] line_buffer,
  output logic [7:0]                 xmin,
  output logic [7:0]                 ymin,
  output logic                       clip_err,
  output logic [1:0]                 dbg_state
);

  localparam int NBITS = BOX_DIM * BOX_DIM;
  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [8:0] BOX_LIM = 9'(BOX_DIM);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDGE_INIT = 2'd1,
    EDGE_STEP = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse while in DONE.
  state_t            state_q, state_d;
  logic [47:0]       coord_q, coord_d;
  logic [7:0]        xmin_q, xmin_d, ymin_q, ymin_d;
  logic [NBITS-1:0]  lb_q, lb_d;
  logic              valid_q, valid_d;
  logic [1:0]        k_q, k_d;
  logic [7:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]        end_x_q, end_x_d, end_y_q, end_y_d;
  logic [7:0]        dx_q, dx_d, dy_q, dy_d;
  logic              sx_q, sx_d, sy_q, sy_d;
  logic signed [9:0] err_q, err_d;
  logic              clip_d;

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Endpoints of edge k, relative to the latched bounding-box origin.
  logic [7:0] xa_rel, ya_rel, xb_rel, yb_rel;
  always_comb begin
    xa_rel = coord_q[39:32] - xmin_q;
    ya_rel = coord_q[47:40] - ymin_q;
    xb_rel = coord_q[7:0]   - xmin_q;
    yb_rel = coord_q[15:8]  - ymin_q;
    case (k_q)
      2'd0: begin
        xa_rel = coord_q[7:0]   - xmin_q;
        ya_rel = coord_q[15:8]  - ymin_q;
        xb_rel = coord_q[23:16] - xmin_q;
        yb_rel = coord_q[31:24] - ymin_q;
      end
      2'd1: begin
        xa_rel = coord_q[23:16] - xmin_q;
        ya_rel = coord_q[31:24] - ymin_q;
        xb_rel = coord_q[39:32] - xmin_q;
        yb_rel = coord_q[47:40] - ymin_q;
      end
      default: ;
    endcase
  end

  logic [7:0]         init_dx, init_dy;
  logic signed [10:0] e2;
  logic               step_x, step_y, at_end, in_win;
  logic [IDX_W-1:0]   pix_idx;

  assign init_dx = (xb_rel >= xa_rel) ? (xb_rel - xa_rel) : (xa_rel - xb_rel);
  assign init_dy = (yb_rel >= ya_rel) ? (yb_rel - ya_rel) : (ya_rel - yb_rel);
  assign e2      = $signed({err_q, 1'b0});
  assign step_x  = e2 > -$signed({3'b000, dy_q});
  assign step_y  = e2 < $signed({3'b000, dx_q});
  assign at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign in_win  = ({1'b0, cur_x_q} < BOX_LIM) && ({1'b0, cur_y_q} < BOX_LIM);
  assign pix_idx = IDX_W'(cur_y_q) * IDX_W'(BOX_DIM) + IDX_W'(cur_x_q);

  always_comb begin
    state_d = state_q;
    coord_d = coord_q;
    xmin_d  = xmin_q;
    ymin_d  = ymin_q;
    lb_d    = lb_q;
    valid_d = valid_q;
    k_d     = k_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    end_x_d = end_x_q;
    end_y_d = end_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    clip_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          coord_d = coordinates;
          xmin_d  = min3(coordinates[7:0], coordinates[23:16], coordinates[39:32]);
          ymin_d  = min3(coordinates[15:8], coordinates[31:24], coordinates[47:40]);
          lb_d    = '0;
          valid_d = 1'b0;
          k_d     = 2'd0;
          state_d = EDGE_INIT;
        end
      end
      EDGE_INIT: begin
        cur_x_d = xa_rel;
        cur_y_d = ya_rel;
        end_x_d = xb_rel;
        end_y_d = yb_rel;
        dx_d    = init_dx;
        dy_d    = init_dy;
        sx_d    = xb_rel >= xa_rel;
        sy_d    = yb_rel >= ya_rel;
        err_d   = $signed({2'b00, init_dx}) - $signed({2'b00, init_dy});
        state_d = EDGE_STEP;
      end
      EDGE_STEP: begin
        if (in_win) lb_d[pix_idx] = 1'b1;
        else        clip_d        = 1'b1;
        if (at_end) begin
          if (k_q == 2'd2) begin
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = EDGE_INIT;
          end
        end else begin
          if (step_x && step_y)
            err_d = err_q - $signed({2'b00, dy_q}) + $signed({2'b00, dx_q});
          else if (step_x)
            err_d = err_q - $signed({2'b00, dy_q});
          else if (step_y)
            err_d = err_q + $signed({2'b00, dx_q});
          if (step_x) cur_x_d = sx_q ? cur_x_q + 8'd1 : cur_x_q - 8'd1;
          if (step_y) cur_y_d = sy_q ? cur_y_q + 8'd1 : cur_y_q - 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      coord_q <= '0;
      xmin_q  <= '0;
      ymin_q  <= '0;
      lb_q    <= '0;
      valid_q <= 1'b0;
      k_q     <= 2'd0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      coord_q <= coord_d;
      xmin_q  <= xmin_d;
      ymin_q  <= ymin_d;
      lb_q    <= lb_d;
      valid_q <= valid_d;
      k_q     <= k_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

`ifdef EDGE_RASTER_CLIP_DETECT_EN
  logic clip_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                       clip_q <= 1'b0;
    else if (state_q == IDLE && start) clip_q <= 1'b0;
    else if (clip_d)                  clip_q <= 1'b1;
  end
  assign clip_err = clip_q;
`else
  // Out-of-window pixels are still dropped; only the report is absent.
  logic unused_clip;
  assign unused_clip = clip_d;
  assign clip_err    = 1'b0;
`endif

  assign busy         = (state_q == EDGE_INIT) || (state_q == EDGE_STEP);
  assign done         = (state_q == DONE);
  assign raster_valid = valid_q;
  assign line_buffer  = lb_q;
  assign xmin         = xmin_q;
  assign ymin         = ymin_q;
  assign dbg_state    = state_q;

endmodule
